// File: rtl/machine_timer.sv
// rtl/machine_timer.sv - 64-bit machine timer with prescaler, compare and auto-reload
// Register window of eight words. The level interrupt is raised while PEND and IE are set.
// A one-cycle end pulse follows a software clear of PEND.
module machine_timer #(
  parameter int ADDR_W  = 5,
  parameter int PRESC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              resp_valid,
  output logic              intr_t,
  output logic              intr_end_t
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] A_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] A_STATUS = IDX_W'(1);
  localparam logic [IDX_W-1:0] A_PRESC  = IDX_W'(2);
  localparam logic [IDX_W-1:0] A_MLO    = IDX_W'(3);
  localparam logic [IDX_W-1:0] A_MHI    = IDX_W'(4);
  localparam logic [IDX_W-1:0] A_CLO    = IDX_W'(5);
  localparam logic [IDX_W-1:0] A_CHI    = IDX_W'(6);
  localparam logic [IDX_W-1:0] A_PERIOD = IDX_W'(7);

  logic               en, ie, auto_rl, pend;
  logic [PRESC_W-1:0] presc, pcnt;
  logic [63:0]        mtime, mtimecmp, mtime_nxt, cmp_nxt;
  logic [31:0]        period, shadow, rd_val;
  logic [IDX_W-1:0]   widx;
  logic               wr, rd, tick, match, w1c;

  assign widx  = addr[ADDR_W-1:2];
  assign wr    = req & we;
  assign rd    = req & ~we;
  assign tick  = en & (pcnt == presc);
  assign match = en & (mtime >= mtimecmp);
  assign w1c   = wr & (widx == A_STATUS) & wdata[0];

  assign intr_t = pend & ie;

  // Next mtime: tick increment, then a bus write overrides only its own half with the pre-tick other half
  always_comb begin
    mtime_nxt = tick ? mtime + 64'd1 : mtime;
    if (wr && widx == A_MLO) mtime_nxt = {mtime[63:32], wdata};
    if (wr && widx == A_MHI) mtime_nxt = {wdata, mtime[31:0]};
  end

  // Next compare: auto-reload first, then a bus write overrides only the half it targets
  always_comb begin
    cmp_nxt = (match && auto_rl) ? mtimecmp + {32'd0, period} : mtimecmp;
    if (wr && widx == A_CLO) cmp_nxt[31:0]  = wdata;
    if (wr && widx == A_CHI) cmp_nxt[63:32] = wdata;
  end

  // Read mux; MTIME_HI returns the shadow captured by the last MTIME_LO read
  always_comb begin
    rd_val = 32'd0;
    case (widx)
      A_CTRL:   rd_val = {29'd0, auto_rl, ie, en};
      A_STATUS: rd_val = {31'd0, pend};
      A_PRESC:  rd_val = {{(32-PRESC_W){1'b0}}, presc};
      A_MLO:    rd_val = mtime[31:0];
      A_MHI:    rd_val = shadow;
      A_CLO:    rd_val = mtimecmp[31:0];
      A_CHI:    rd_val = mtimecmp[63:32];
      A_PERIOD: rd_val = period;
      default:  rd_val = 32'd0;
    endcase
  end

  // Config registers, prescaler, timer state and bus response
  always_ff @(posedge clk) begin
    if (rst) begin
      en         <= 1'b0;
      ie         <= 1'b0;
      auto_rl    <= 1'b0;
      presc      <= '0;
      period     <= 32'd0;
      pcnt       <= '0;
      mtime      <= 64'd0;
      mtimecmp   <= '1;
      shadow     <= 32'd0;
      rdata      <= 32'd0;
      resp_valid <= 1'b0;
    end else begin
      if (wr && widx == A_CTRL) begin
        en      <= wdata[0];
        ie      <= wdata[1];
        auto_rl <= wdata[2];
      end
      if (wr && widx == A_PRESC)  presc  <= wdata[PRESC_W-1:0];
      if (wr && widx == A_PERIOD) period <= wdata;
      if (wr && (widx == A_CTRL || widx == A_PRESC)) pcnt <= '0;
      else if (en) pcnt <= tick ? '0 : pcnt + PRESC_W'(1);
      mtime    <= mtime_nxt;
      mtimecmp <= cmp_nxt;
      if (rd && widx == A_MLO) shadow <= mtime[63:32];
      if (rd) rdata <= rd_val;
      resp_valid <= req;
    end
  end

  // Sticky pending flag (set beats clear) and end-of-interrupt pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      pend       <= 1'b0;
      intr_end_t <= 1'b0;
    end else begin
      if (match)    pend <= 1'b1;
      else if (w1c) pend <= 1'b0;
      intr_end_t <= w1c & pend & ~match;
    end
  end

endmodule
